// File: rtl/run_sequencer_pkg.sv
// run_sequencer_pkg: shared widths, FSM state encoding and helpers for the
// benchmark run sequencer (run_sequencer, run_stats, run_sequencer_if).
package run_sequencer_pkg;

  localparam int unsigned RUN_CNT_W = 32;
  localparam int unsigned TOTAL_W   = 40;
  localparam int unsigned RUNS_W    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    REPORT = 3'd4
  } state_e;

  typedef logic [RUN_CNT_W-1:0] cycles_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic cycles_t sat_inc(input cycles_t v);
    return (v == '1) ? v : v + RUN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// run_sequencer_if: host/DUT-facing bundle of the run sequencer.
//   start_i, num_runs_i     : batch request and run count
//   go_o, done_i            : launch pulse to / completion from the DUT
//   busy_o, result_valid_o  : sequencer status
//   min/max/total_cycles_o, runs_done_o, timeout_o : batch statistics
// Modports: master = host side (bench), slave = sequencer side.
interface run_sequencer_if;
  import run_sequencer_pkg::*;

  logic                 start_i;
  logic [RUNS_W-1:0]    num_runs_i;
  logic                 go_o;
  logic                 done_i;
  logic                 busy_o;
  logic                 result_valid_o;
  logic [RUN_CNT_W-1:0] min_cycles_o;
  logic [RUN_CNT_W-1:0] max_cycles_o;
  logic [TOTAL_W-1:0]   total_cycles_o;
  logic [RUNS_W-1:0]    runs_done_o;
  logic                 timeout_o;

  modport master (
    output start_i, num_runs_i, done_i,
    input  go_o, busy_o, result_valid_o, min_cycles_o, max_cycles_o,
           total_cycles_o, runs_done_o, timeout_o
  );

  modport slave (
    input  start_i, num_runs_i, done_i,
    output go_o, busy_o, result_valid_o, min_cycles_o, max_cycles_o,
           total_cycles_o, runs_done_o, timeout_o
  );
endinterface

// File: rtl/run_sequencer_stats.sv
// run_stats: accumulates min/max/total/count of completed run lengths.
//   clk, reset (async, active-low)
//   clear  : start a new batch (min/max/total/count -> empty)
//   update : one run finished with the given length
//   outputs are registered; min_cycles reads 0 until the first run lands.
module run_stats
  import run_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 update,
  input  logic [RUN_CNT_W-1:0] length,
  output logic [RUN_CNT_W-1:0] min_cycles,
  output logic [RUN_CNT_W-1:0] max_cycles,
  output logic [TOTAL_W-1:0]   total_cycles,
  output logic [RUNS_W-1:0]    runs_done
);

  // Running minimum starts at all-ones so the first run always wins;
  // the visible min_cycles stays 0 until then.
  cycles_t min_acc;
  cycles_t min_next_c;

  assign min_next_c = (length < min_acc) ? length : min_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_acc      <= '1;
      min_cycles   <= '0;
      max_cycles   <= '0;
      total_cycles <= '0;
      runs_done    <= '0;
    end else if (clear) begin
      min_acc      <= '1;
      min_cycles   <= '0;
      max_cycles   <= '0;
      total_cycles <= '0;
      runs_done    <= '0;
    end else if (update) begin
      min_acc      <= min_next_c;
      min_cycles   <= min_next_c;
      if (length > max_cycles) max_cycles <= length;
      total_cycles <= total_cycles + TOTAL_W'(length);
      runs_done    <= runs_done + RUNS_W'(1);
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: launches a batch of DUT runs, times each one and reports
// min/max/total run length.
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset, forces IDLE, outputs 0
//   bus (slave)    : start/num_runs request, go/done DUT handshake, stats
// Optional watchdog: define RUN_SEQ_TIMEOUT_EN to abort a WAIT that reaches
// TIMEOUT_CYCLES without done_i; otherwise timeout_o is tied to 0.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  run_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [RUNS_W-1:0] num_q;
  cycles_t           cnt_q;
  logic              go_q, busy_q, valid_q;
  logic              clear_c, update_c, abort_c, last_run_c;
  logic [RUNS_W-1:0] runs_done;

  // The run being completed now is the last one of the batch.
  assign last_run_c = (RUNS_W'(runs_done + RUNS_W'(1)) == num_q);

`ifdef RUN_SEQ_TIMEOUT_EN
  localparam cycles_t TIMEOUT_LIMIT = RUN_CNT_W'(TIMEOUT_CYCLES);
  logic timeout_q;

  assign abort_c = (state_q == WAIT) && !bus.done_i && (cnt_q >= TIMEOUT_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       timeout_q <= 1'b0;
    else if (clear_c) timeout_q <= 1'b0;
    else if (abort_c) timeout_q <= 1'b1;
  end

  assign bus.timeout_o = timeout_q;
`else
  assign abort_c       = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start_i) state_d = (bus.num_runs_i == '0) ? REPORT : LAUNCH;
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (bus.done_i)   state_d = last_run_c ? REPORT : GAP;
        else if (abort_c) state_d = REPORT;
      end
      GAP:    state_d = LAUNCH;
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    clear_c  = 1'b0;
    update_c = 1'b0;
    case (state_q)
      IDLE:    clear_c  = bus.start_i;
      WAIT:    update_c = bus.done_i;
      default: ;
    endcase
  end

  // Datapath and registered outputs; go/busy are derived from the state
  // being entered so they line up with LAUNCH / non-IDLE cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_q   <= '0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      go_q   <= (state_d == LAUNCH);
      busy_q <= (state_d != IDLE);
      if (clear_c) num_q <= bus.num_runs_i;
      if (state_q == LAUNCH)                cnt_q <= '0;
      else if (state_q == WAIT && !bus.done_i) cnt_q <= sat_inc(cnt_q);
      if (clear_c)                 valid_q <= 1'b0;
      else if (state_q == REPORT)  valid_q <= 1'b1;
    end
  end

  assign bus.go_o           = go_q;
  assign bus.busy_o         = busy_q;
  assign bus.result_valid_o = valid_q;
  assign bus.runs_done_o    = runs_done;

  run_stats u_stats (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear_c),
    .update       (update_c),
    .length       (cnt_q),
    .min_cycles   (bus.min_cycles_o),
    .max_cycles   (bus.max_cycles_o),
    .total_cycles (bus.total_cycles_o),
    .runs_done    (runs_done)
  );

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed, table-driven bench for run_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
// Define RUN_SEQ_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_run_sequencer;
  import run_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  run_sequencer_if bus();

  run_sequencer #(.TIMEOUT_CYCLES(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0]       num;
    logic [3:0][7:0]  len;
    logic             pulse;
    logic [31:0]      emin;
    logic [31:0]      emax;
    logic [39:0]      etot;
    logic [7:0]       eruns;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] num, input logic [7:0] l0,
                              input logic [7:0] l1, input logic [7:0] l2,
                              input logic [7:0] l3, input logic pulse,
                              input logic [31:0] emin, input logic [31:0] emax,
                              input logic [39:0] etot, input logic [7:0] eruns);
    vec_t v;
    v.num = num; v.len = {l3, l2, l1, l0}; v.pulse = pulse;
    v.emin = emin; v.emax = emax; v.etot = etot; v.eruns = eruns;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // go must never be high on two consecutive cycles
  logic go_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.go_o === 1'b1 && go_prev === 1'b1) begin
      n_err++;
      $display("FAIL go_back_to_back: got go high twice in a row, expected single pulse");
    end
    go_prev = bus.go_o;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_go"},      64'(bus.go_o), 64'd0);
    check({tag, "_busy"},    64'(bus.busy_o), 64'd0);
    check({tag, "_valid"},   64'(bus.result_valid_o), 64'd0);
    check({tag, "_min"},     64'(bus.min_cycles_o), 64'd0);
    check({tag, "_max"},     64'(bus.max_cycles_o), 64'd0);
    check({tag, "_total"},   64'(bus.total_cycles_o), 64'd0);
    check({tag, "_runs"},    64'(bus.runs_done_o), 64'd0);
    check({tag, "_timeout"}, 64'(bus.timeout_o), 64'd0);
  endtask

  task automatic check_stats(input string tag, input vec_t v, input logic exp_to);
    check({tag, "_min"},     64'(bus.min_cycles_o), 64'(v.emin));
    check({tag, "_max"},     64'(bus.max_cycles_o), 64'(v.emax));
    check({tag, "_total"},   64'(bus.total_cycles_o), 64'(v.etot));
    check({tag, "_runs"},    64'(bus.runs_done_o), 64'(v.eruns));
    check({tag, "_timeout"}, 64'(bus.timeout_o), 64'(exp_to));
    check({tag, "_busy"},    64'(bus.busy_o), 64'd0);
  endtask

  task automatic wait_go(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.go_o === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (bus.result_valid_o === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic start_batch(input logic [7:0] num);
    bus.num_runs_i = num;
    bus.start_i    = 1'b1;
    @(negedge clk);
    bus.start_i    = 1'b0;
    bus.num_runs_i = 8'hFF;  // must have been latched already
  endtask

  // Launch, answer with done_i after len WAIT cycles, one run at a time.
  task automatic do_run(input string tag, input int len, input bit pulse);
    bit ok;
    wait_go(ok);
    check({tag, "_go_seen"}, 64'(ok), 64'd1);
    @(negedge clk);
    for (int k = 0; k < len; k++) begin
      bus.start_i = pulse && (k == 0);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    bus.done_i  = 1'b1;
    @(negedge clk);
    bus.done_i  = 1'b0;
  endtask

  task automatic run_batch(input string tag, input vec_t v);
    bit ok;
    start_batch(v.num);
    for (int r = 0; r < int'(v.num); r++)
      do_run(tag, int'(v.len[r]), v.pulse && (r == 0));
    wait_valid(10, ok);
    check({tag, "_valid_seen"}, 64'(ok), 64'd1);
    check_stats(tag, v, 1'b0);
  endtask

  vec_t tbl[6];

  initial begin
    bit ok;
    int go_cnt, first_go, second_go;

    tbl[0] = mk(8'd3, 8'd10, 8'd5, 8'd7, 8'd0, 1'b0, 32'd5, 32'd10, 40'd22, 8'd3);
    tbl[1] = mk(8'd3, 8'd10, 8'd5, 8'd7, 8'd0, 1'b1, 32'd5, 32'd10, 40'd22, 8'd3);
    tbl[2] = mk(8'd1, 8'd3,  8'd0, 8'd0, 8'd0, 1'b0, 32'd3, 32'd3,  40'd3,  8'd1);
    tbl[3] = mk(8'd4, 8'd1,  8'd9, 8'd0, 8'd2, 1'b0, 32'd0, 32'd9,  40'd12, 8'd4);
    tbl[4] = mk(8'd2, 8'd6,  8'd6, 8'd0, 8'd0, 1'b0, 32'd6, 32'd6,  40'd12, 8'd2);
    tbl[5] = mk(8'd2, 8'd0,  8'd0, 8'd0, 8'd0, 1'b0, 32'd0, 32'd0,  40'd0,  8'd2);

    reset = 1'b0;
    bus.start_i = 1'b0;
    bus.num_runs_i = '0;
    bus.done_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(bus.busy_o), 64'd0);

    for (int i = 0; i < 6; i++)
      run_batch($sformatf("vec%0d", i), tbl[i]);

    // DUT holding done_i high: GAP keeps the two launches 3 cycles apart
    bus.done_i = 1'b1;
    start_batch(8'd2);
    go_cnt = 0; first_go = -1; second_go = -1;
    for (int t = 0; t < 20; t++) begin
      if (bus.go_o === 1'b1) begin
        if (go_cnt == 0) first_go = t;
        else if (go_cnt == 1) second_go = t;
        go_cnt++;
      end
      @(negedge clk);
    end
    bus.done_i = 1'b0;
    check("done_high_go_count", 64'(go_cnt), 64'd2);
    check("done_high_go_spacing", 64'(second_go - first_go), 64'd3);
    check("done_high_valid", 64'(bus.result_valid_o), 64'd1);
    check_stats("done_high", mk(8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0,
                                32'd0, 32'd0, 40'd0, 8'd2), 1'b0);

    // Zero-run batch: straight to REPORT, valid two cycles after start
    start_batch(8'd0);
    check("zero_valid_c1", 64'(bus.result_valid_o), 64'd0);
    check("zero_go_c1",    64'(bus.go_o), 64'd0);
    check("zero_busy_c1",  64'(bus.busy_o), 64'd1);
    @(negedge clk);
    check("zero_valid_c2", 64'(bus.result_valid_o), 64'd1);
    check("zero_go_c2",    64'(bus.go_o), 64'd0);
    check_stats("zero", mk(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0,
                           32'd0, 32'd0, 40'd0, 8'd0), 1'b0);

    // Reset during WAIT of run 2 clears everything immediately
    start_batch(8'd2);
    do_run("rst_mid_r1", 4, 1'b0);
    wait_go(ok);
    check("rst_mid_go2_seen", 64'(ok), 64'd1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;

    // Reset while go is high drops it at once
    start_batch(8'd1);
    check("rst_go_before", 64'(bus.go_o), 64'd1);
    #2 reset = 1'b0;
    #1 check("rst_go_after", 64'(bus.go_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_batch("post_reset", mk(8'd1, 8'd6, 8'd0, 8'd0, 8'd0, 1'b0,
                               32'd6, 32'd6, 40'd6, 8'd1));

`ifdef RUN_SEQ_TIMEOUT_EN
    // Watchdog: run 1 completes in 4, run 2 never answers
    start_batch(8'd2);
    do_run("to_r1", 4, 1'b0);
    wait_go(ok);
    check("to_go2_seen", 64'(ok), 64'd1);
    wait_valid(60, ok);
    check("to_valid_seen", 64'(ok), 64'd1);
    check_stats("to", mk(8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0,
                         32'd4, 32'd4, 40'd4, 8'd1), 1'b1);
`else
    // No watchdog: a silent DUT keeps the sequencer waiting
    start_batch(8'd1);
    wait_go(ok);
    check("silent_go_seen", 64'(ok), 64'd1);
    repeat (40) @(negedge clk);
    check("silent_busy",    64'(bus.busy_o), 64'd1);
    check("silent_valid",   64'(bus.result_valid_o), 64'd0);
    check("silent_timeout", 64'(bus.timeout_o), 64'd0);
    check("silent_runs",    64'(bus.runs_done_o), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000: WAIT-state cycle limit before abort (used only with RUN_SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start_i, input, 1: request a benchmark batch; sampled in IDLE only.
REQ-005 SHALL have port num_runs_i, input, 8: runs in the batch; sampled when start_i is accepted.
REQ-006 SHALL have port go_o, output, 1: one-cycle launch pulse to the DUT.
REQ-007 SHALL have port done_i, input, 1: DUT completion; honoured in WAIT only.
REQ-008 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-009 SHALL have port result_valid_o, output, 1: statistics outputs valid.
REQ-010 SHALL have ports min_cycles_o and max_cycles_o, output, 32 each: shortest and longest completed run.
REQ-011 SHALL have port total_cycles_o, output, 40: sum of completed run lengths.
REQ-012 SHALL have port runs_done_o, output, 8: completed runs.
REQ-013 SHALL have port timeout_o, output, 1: batch aborted by watchdog.

Function
REQ-014 SHALL implement states IDLE, LAUNCH, WAIT, GAP and REPORT.
REQ-015 IDLE: when start_i=1, SHALL latch num_runs_i, clear stats, drop result_valid_o and timeout_o, then go to LAUNCH; if num_runs_i=0, SHALL go straight to REPORT.
REQ-016 LAUNCH: SHALL assert go_o for exactly one cycle, clear the run counter, then go to WAIT.
REQ-017 WAIT: with done_i=0, the run counter SHALL increment by 1 per cycle and saturate at 0xFFFFFFFF.
REQ-018 WAIT: with done_i=1, run length SHALL equal the current counter value; done_i in the first WAIT cycle gives length 0.
REQ-019 On each completed run, SHALL update min/max, add the length to the 40-bit total (never overflows for 255 x 32-bit) and increment runs_done.
REQ-020 After a completed run, SHALL go to REPORT if runs_done equals the latched count, else to GAP.
REQ-021 GAP: SHALL last exactly one cycle, then go to LAUNCH, so a DUT holding done_i high is not re-sampled.
REQ-022 REPORT: SHALL assert result_valid_o, go to IDLE next cycle, and hold result_valid_o and all stats until the next accepted start_i.
REQ-023 Internal min SHALL initialise to 0xFFFFFFFF; min_cycles_o SHALL read 0 when runs_done_o=0.
REQ-024 start_i while busy_o=1, and done_i outside WAIT, SHALL be ignored.
REQ-025 go_o SHALL never be high in two consecutive cycles.

Reset
REQ-026 reset=0 SHALL immediately force IDLE and set every output to 0, including mid-run (go_o dropped at once).
REQ-027 After reset is released, the first accepted start_i SHALL behave identically to a power-on start.

Configuration
REQ-028 With macro RUN_SEQ_TIMEOUT_EN defined, WAIT SHALL abort when the counter reaches TIMEOUT_CYCLES with done_i=0.
REQ-029 On abort, SHALL set timeout_o=1, exclude the aborted run from stats and go to REPORT.
REQ-030 Without RUN_SEQ_TIMEOUT_EN, timeout_o SHALL be constant 0, WAIT SHALL wait indefinitely, and no watchdog logic SHALL exist.

Structure
REQ-031 A shared package SHALL hold the state enum, RUN_CNT_W=32, TOTAL_W=40 and RUNS_W=8.
REQ-032 Min/max/total/runs_done update logic SHALL be one sub-module, run_stats (inputs: clear, update, length).

Verification
REQ-033 num_runs_i=3, DUT done after 10, 5, 7 WAIT cycles -> min=5, max=10, total=22, runs_done=3, result_valid=1, timeout=0.
REQ-034 done_i tied high, num_runs_i=2 -> two go_o pulses separated by GAP, min=max=0, total=0, runs_done=2.
REQ-035 num_runs_i=0 -> no go_o pulse, result_valid_o high 2 cycles after start, all stats 0.
REQ-036 With RUN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=20, num_runs_i=2, run 1 = 4 cycles, DUT then silent -> timeout=1, runs_done=1, min=max=total=4.
REQ-037 reset asserted in WAIT of run 2, then start_i with num_runs_i=1 and 6-cycle DUT -> all outputs 0 during reset, then min=max=total=6, runs_done=1.
REQ-038 start_i pulsed during WAIT -> ignored; batch results unchanged versus the same batch without the pulse.
